quad_gen: RTL and testbench

QUAD_GEN -- requirements
Module: quad_gen

---
 rtl/motorboard_pkg.sv | 22 ++
 rtl/quad_gen.sv | 118 +++++++++++
 tb/tb_quad_gen.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/motorboard_pkg.sv
// Shared definitions for the quadrature step generator: FSM encoding and the
// forward/reverse (A,B) phase tables.
package motorboard_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } qg_state_e;

  // Next {A,B} packed by current {A,B}: entry n lives in bits [2n+1:2n].
  // Forward 00->10->11->01->00, reverse 00->01->11->10->00.
  localparam logic [7:0] PHASE_FWD = 8'b01_11_00_10;
  localparam logic [7:0] PHASE_REV = 8'b10_00_11_01;

  function automatic logic [1:0] phase_next(input logic [1:0] ab, input logic rev);
    logic [7:0] tbl;
    tbl = rev ? PHASE_REV : PHASE_FWD;
    return tbl[{ab, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/quad_gen.sv
// Quadrature step generator: emits a signed number of A/B edges at a fixed
// clk-cycle period, tracking position and supporting freeze and abort.
module quad_gen
  import motorboard_pkg::*;
#(
  parameter int STEP_W = 24,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic [DIV_W-1:0]  cmd_period,
  input  logic              ena,
  input  logic              abort,
  output logic              quadA,
  output logic              quadB,
  output logic [STEP_W-1:0] position,
  output logic              busy,
  output logic              done
);

  localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);
  localparam logic [DIV_W-1:0]  DIV_ONE  = DIV_W'(1);

  qg_state_e         state_q, state_d;
  logic [1:0]        ab_q, ab_d;
  logic [STEP_W-1:0] pos_q, pos_d;
  logic [STEP_W-1:0] rem_q, rem_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [DIV_W-1:0]  per_q, per_d;
  logic              dir_q, dir_d;
  logic              done_q, done_d;
  logic              handshake;

  assign cmd_ready = reset_n && (state_q == ST_IDLE);
  assign busy      = reset_n && (state_q != ST_IDLE);
  assign handshake = cmd_valid && cmd_ready;

  always_comb begin
    state_d = state_q;
    ab_d    = ab_q;
    pos_d   = pos_q;
    rem_d   = rem_q;
    div_d   = div_q;
    per_d   = per_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (handshake) begin
          if (cmd_steps == '0) begin
            done_d = 1'b1;
          end else begin
            // Two's-complement magnitude; the most negative count maps to 2^(STEP_W-1).
            rem_d   = cmd_steps[STEP_W-1] ? (~cmd_steps + STEP_ONE) : cmd_steps;
            dir_d   = cmd_steps[STEP_W-1];
            per_d   = (cmd_period == '0) ? DIV_ONE : cmd_period;
            div_d   = (cmd_period == '0) ? DIV_ONE : cmd_period;
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        // Abort wins over a divider expiry in the same cycle.
        if (abort) begin
          state_d = ST_IDLE;
        end else if (ena) begin
          if (div_q <= DIV_ONE) begin
            ab_d  = phase_next(ab_q, dir_q);
            pos_d = dir_q ? (pos_q - STEP_ONE) : (pos_q + STEP_ONE);
            rem_d = rem_q - STEP_ONE;
            div_d = per_q;
            if (rem_q == STEP_ONE) begin
              state_d = ST_DONE;
            end
          end else begin
            div_d = div_q - DIV_ONE;
          end
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ab_q    <= 2'b00;
      pos_q   <= '0;
      rem_q   <= '0;
      div_q   <= '0;
      per_q   <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ab_q    <= ab_d;
      pos_q   <= pos_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      per_q   <= per_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end

  assign quadA    = ab_q[1];
  assign quadB    = ab_q[0];
  assign position = pos_q;
  assign done     = done_q;

endmodule

// File: tb/tb_quad_gen.sv
// Directed and random checks of quad_gen: expected edges are queued at command
// time and popped as the outputs change; an independent decoder tracks position.
module tb_quad_gen;

  localparam int STEP_W = 24;
  localparam int DIV_W  = 16;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [STEP_W-1:0] cmd_steps;
  logic [DIV_W-1:0]  cmd_period;
  logic              ena;
  logic              abort;
  logic              quadA;
  logic              quadB;
  logic [STEP_W-1:0] position;
  logic              busy;
  logic              done;

  always #5 clk = ~clk;

  quad_gen #(.STEP_W(STEP_W), .DIV_W(DIV_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_steps  (cmd_steps),
    .cmd_period (cmd_period),
    .ena        (ena),
    .abort      (abort),
    .quadA      (quadA),
    .quadB      (quadB),
    .position   (position),
    .busy       (busy),
    .done       (done)
  );

  typedef struct {
    int                c;
    logic [1:0]        ab;
    logic [STEP_W-1:0] pos;
  } ev_t;

  ev_t               exp_q[$];
  int                cyc = 0;
  int                total = 0;
  int                bad = 0;
  int                exp_done = -1;
  int                ena_off = -1;
  int                ena_on = -1;
  int                abort_at = -1;
  logic [1:0]        m_ab;
  logic [1:0]        prev_ab;
  logic [STEP_W-1:0] m_pos;
  logic [1:0]        dec_prev;
  logic [STEP_W-1:0] dec_cnt;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [1:0] fwd_next(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] rev_next(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  // Reference quadrature decoder fed from the generator outputs.
  always @(posedge clk) begin
    if (!reset_n) begin
      dec_prev <= 2'b00;
      dec_cnt  <= '0;
    end else begin
      dec_prev <= {quadA, quadB};
      if ({quadA, quadB} == fwd_next(dec_prev))
        dec_cnt <= dec_cnt + 24'd1;
      else if ({quadA, quadB} == rev_next(dec_prev))
        dec_cnt <= dec_cnt - 24'd1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // One cycle: sample at the falling edge, score edges and done, then drive ena/abort.
  task automatic step();
    ev_t e;
    @(negedge clk);
    if ({quadA, quadB} !== prev_ab) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_edge", {30'b0, quadA, quadB}, {30'b0, prev_ab});
      end else begin
        e = exp_q.pop_front();
        chk("edge_cycle", cyc, e.c);
        chk("edge_ab", {30'b0, quadA, quadB}, {30'b0, e.ab});
        chk("edge_pos", 32'(position), 32'(e.pos));
      end
      prev_ab = {quadA, quadB};
    end else if (exp_q.size() != 0 && exp_q[0].c <= cyc) begin
      chk("missing_edge_ab", {30'b0, quadA, quadB}, {30'b0, exp_q[0].ab});
      void'(exp_q.pop_front());
    end
    if (done === 1'b1 || cyc == exp_done)
      chk("done_pulse", 32'(done), 32'(cyc == exp_done));
    ena   = !(cyc >= ena_off && cyc < ena_on);
    abort = (cyc + 1 == abort_at);
  endtask

  // Queue expected edges; edges numbered >= stop_edge never happen (abort/reset).
  task automatic push_move(input int hs, input int steps, input int per,
                           input int stall_edge, input int stall_len, input int stop_edge);
    int  n;
    int  p;
    int  c;
    ev_t e;
    n = (steps < 0) ? -steps : steps;
    p = (per == 0) ? 1 : per;
    c = hs;
    for (int k = 1; k <= n; k++) begin
      if (k >= stop_edge) begin
        exp_done = -1;
        return;
      end
      c     = hs + k * p + ((k > stall_edge) ? stall_len : 0);
      m_ab  = (steps < 0) ? rev_next(m_ab) : fwd_next(m_ab);
      m_pos = (steps < 0) ? (m_pos - 24'd1) : (m_pos + 24'd1);
      e.c   = c;
      e.ab  = m_ab;
      e.pos = m_pos;
      exp_q.push_back(e);
    end
    exp_done = (n == 0) ? hs : c + 1;
  endtask

  task automatic send(input int steps, input int per, input int stall_edge,
                      input int stall_len, input int stop_edge, output int hs);
    cmd_valid  = 1'b1;
    cmd_steps  = STEP_W'(steps);
    cmd_period = DIV_W'(per);
    chk("cmd_ready_before_cmd", 32'(cmd_ready), 32'd1);
    hs = cyc + 1;
    push_move(hs, steps, per, stall_edge, stall_len, stop_edge);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_ab", {30'b0, quadA, quadB}, 32'd0);
      chk("rst_pos", 32'(position), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_ready", 32'(cmd_ready), 32'd0);
    end
    reset_n = 1'b1;
    prev_ab = 2'b00;
    m_ab    = 2'b00;
    m_pos   = '0;
    chk("rst_queue_empty", exp_q.size(), 32'd0);
    exp_q.delete();
    exp_done = -1;
    step();
    chk("ready_after_rst", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    int hs;
    int st;
    int pr;
    reset_n    = 1'b0;
    cmd_valid  = 1'b0;
    cmd_steps  = '0;
    cmd_period = '0;
    ena        = 1'b1;
    abort      = 1'b0;
    prev_ab    = 2'b00;
    m_ab       = 2'b00;
    m_pos      = '0;

    do_reset();

    // Reset in the middle of a move with 50 steps still pending.
    send(100, 1, 0, 0, 51, hs);
    repeat (50) step();
    chk("pre_rst_pos", 32'(position), 32'd50);
    do_reset();
    chk("post_rst_busy", 32'(busy), 32'd0);

    // Freeze after edge 2, then abort exactly when edge 5 would fire.
    send(10, 4, 2, 7, 5, hs);
    ena_off  = hs + 8;
    ena_on   = hs + 15;
    abort_at = hs + 27;
    repeat (27) step();
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ready", 32'(cmd_ready), 32'd1);
    chk("abort_pos", 32'(position), 32'd4);
    ena_off  = -1;
    ena_on   = -1;
    abort_at = -1;
    repeat (4) step();
    chk("abort_pos_hold", 32'(position), 32'd4);

    // Forward 4 steps at period 3.
    send(4, 3, 0, 0, 1000, hs);
    repeat (16) step();
    chk("fwd_pos", 32'(position), 32'd8);
    chk("fwd_ab", {30'b0, quadA, quadB}, 32'd0);

    // Zero-step command, then period 0 treated as 1.
    send(0, 5, 0, 0, 1000, hs);
    repeat (4) step();
    chk("zero_pos", 32'(position), 32'd8);
    send(2, 0, 0, 0, 1000, hs);
    repeat (5) step();
    chk("per0_pos", 32'(position), 32'd10);

    // Reverse from zero wraps below zero.
    do_reset();
    send(-3, 1, 0, 0, 1000, hs);
    repeat (6) step();
    chk("rev_wrap_pos", 32'(position), 32'h00FF_FFFD);
    chk("rev_ab", {30'b0, quadA, quadB}, 32'd2);

    // Random moves checked against the reference decoder.
    for (int i = 0; i < 6; i++) begin
      st = int'($urandom_range(40)) - 20;
      pr = int'($urandom_range(3));
      send(st, pr, 0, 0, 1000, hs);
      repeat (((st < 0) ? -st : st) * ((pr == 0) ? 1 : pr) + 4) step();
      chk("loop_decoder", 32'(dec_cnt), 32'(position));
      chk("loop_model", 32'(position), 32'(m_pos));
    end

    chk("final_queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
